// File: rtl/iterative_shifter_32_pkg.sv
// Shared constants and types for the iterative 32-bit shift/rotate unit.
package iterative_shifter_32_pkg;

    localparam int WIDTH  = 32;
    localparam int AMT_W  = $clog2(WIDTH);
    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_SLL = 3'd0;
    localparam logic [MODE_W-1:0] MODE_ROL = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SRL = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SRA = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic [MODE_W-1:0] mode;
        logic [AMT_W-1:0]  amount;
        logic [WIDTH-1:0]  data;
    } shiftReq_t;

endpackage

// File: rtl/iterative_shifter_32_if.sv
// Request/response bundle between the CPU control and the iterative shifter.
interface iterative_shifter_32_if;
    import iterative_shifter_32_pkg::*;

    logic              Start;
    logic              Abort;
    logic [MODE_W-1:0] Mode;
    logic [WIDTH-1:0]  DataA;
    logic [AMT_W-1:0]  ShiftAmount;
    logic              Busy;
    logic              Done;
    logic [WIDTH-1:0]  Result;

    modport master (
        output Start, Abort, Mode, DataA, ShiftAmount,
        input  Busy, Done, Result
    );

    modport slave (
        input  Start, Abort, Mode, DataA, ShiftAmount,
        output Busy, Done, Result
    );

endinterface

// File: rtl/iterative_shifter_32_shift_step.sv
// Combinational single-bit step for one shifter iteration; modes 5-7 pass through.
module shift_step_32 import iterative_shifter_32_pkg::*; (
    input  logic [WIDTH-1:0]  w,
    input  logic [MODE_W-1:0] mode,
    output logic [WIDTH-1:0]  next
);

    always_comb begin
        next = w;
        case (mode)
            MODE_SLL: next = {w[WIDTH-2:0], 1'b0};
            MODE_ROL: next = {w[WIDTH-2:0], w[WIDTH-1]};
            MODE_SRL: next = {1'b0, w[WIDTH-1:1]};
            MODE_SRA: next = {w[WIDTH-1], w[WIDTH-1:1]};
            MODE_ROR: next = {w[0], w[WIDTH-1:1]};
            default:  next = w;
        endcase
    end

endmodule

// File: rtl/iterative_shifter_32.sv
// One-bit-per-cycle shift/rotate unit: IDLE -> SHIFT (N steps + 1) -> DONE pulse -> IDLE.
module iterative_shifter_32 import iterative_shifter_32_pkg::*; (
    input  logic                  Clock,
    input  logic                  nReset,
    iterative_shifter_32_if.slave bus
);

    state_e            state;
    shiftReq_t         req;
    logic [AMT_W-1:0]  count;
    logic [WIDTH-1:0]  work;
    logic [WIDTH-1:0]  stepNext;
    logic [WIDTH-1:0]  result;
    logic [MODE_W-1:0] modeReg;
    logic              busy;
    logic              done;

    assign req = '{mode: bus.Mode, amount: bus.ShiftAmount, data: bus.DataA};

    shift_step_32 uStep (
        .w    (work),
        .mode (modeReg),
        .next (stepNext)
    );

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state   <= ST_IDLE;
            count   <= '0;
            work    <= '0;
            modeReg <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Abort wins a tie with Start; on its own it does nothing here
                    if (bus.Start && !bus.Abort) begin
                        work    <= req.data;
                        count   <= req.amount;
                        modeReg <= req.mode;
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bus.Abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (count != '0) begin
                        work  <= stepNext;
                        count <= count - 1'b1;
                    end else begin
                        result <= work;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Busy   = busy;
    assign bus.Done   = done;
    assign bus.Result = result;

endmodule
